timestep_sequencer: RTL and testbench
=====================================

Name: timestep_sequencer

Overview:
Parametrised timestep counter for the processor control unit. Tracks the current timestep of the executing instruction and drives a one-hot timestep bus to the control decoder. Supports variable-length instructions through an end-of-instruction input, stall, and direct load of a timestep. Also keeps saturating performance counters for elapsed cycles and retired instructions.

Parameters:
STEP_W, 2, width of timestep count; number of timesteps NSTEP = 2**STEP_W
PERF_W, 16, width of cycle and instruction performance counters

Ports:
CLKb  in  1  clock; all state updates on falling edge
CLR  in  1  reset, asynchronous, active-high
EN  in  1  1 = advance/act this edge; 0 = stall (hold all state except CLR)
LAST  in  1  current timestep is final step of instruction; next step is 0
LOAD  in  1  force timestep to LD_VAL on next edge
LD_VAL  in  STEP_W  timestep value for LOAD
CNT  out  STEP_W  current timestep
T  out  NSTEP  one-hot decode of CNT (T[i]=1 iff CNT==i)
WRAP  out  1  registered one-edge pulse: timestep went 0 because of LAST or natural wrap
OVF  out  1  sticky: CNT wrapped from NSTEP-1 to 0 without LAST
CYCLES  out  PERF_W  count of edges with EN=1, saturating
INSTRS  out  PERF_W  count of accepted LAST events, saturating

Behaviour:
- CLR=1 (async, any time, incl. mid-instruction): CNT=0, T=1 (bit 0 only), WRAP=0, OVF=0, CYCLES=0, INSTRS=0; held while CLR=1.
- Falling edge of CLKb, CLR=0, EN=0: all registers hold; WRAP clears to 0.
- Falling edge, CLR=0, EN=1, priority LOAD > LAST > count:
  - LOAD=1: CNT<=LD_VAL; WRAP<=0; LAST ignored, INSTRS unchanged.
  - else LAST=1: CNT<=0; WRAP<=1; INSTRS<=INSTRS+1 (saturate).
  - else CNT==NSTEP-1: CNT<=0; WRAP<=1; OVF<=1.
  - else CNT<=CNT+1; WRAP<=0.
  - CYCLES<=CYCLES+1 in all EN=1 cases.
- Saturation: CYCLES/INSTRS stop at 2**PERF_W-1, never wrap.
- T is combinational decode of registered CNT; exactly one bit high at all times, including during and after reset.
- Latency: input effect visible on CNT/T/WRAP one falling edge later; no combinational path from inputs to outputs.
- LAST at CNT==NSTEP-1: treated as LAST (WRAP=1, OVF unchanged, INSTRS+1).
- LOAD with LD_VAL==CNT: CNT unchanged, no WRAP, CYCLES still increments.
- OVF cleared only by CLR.

Test Plan:
- CLR pulse mid-count (CNT=2), no clock edge -> CNT=0, T=0001, OVF=0, CYCLES=0 immediately; remain after CLR released until next falling edge.
- STEP_W=2, EN=1, LAST=0 for 5 edges from reset -> CNT 1,2,3,0,1; WRAP high only after 4th edge; OVF=1 from 4th edge on; CYCLES=5.
- LAST=1 at CNT=1 -> next CNT=0, WRAP=1 for one edge, INSTRS=1, OVF=0; LAST and LOAD together with LD_VAL=2 -> CNT=2, INSTRS unchanged.
- EN=0 for 3 edges at CNT=2 with LAST=1, LOAD=1 -> CNT=2, CYCLES/INSTRS unchanged, WRAP=0.
- PERF_W=4: 20 enabled edges with LAST=1 every edge -> CYCLES=15, INSTRS=15 (saturated), CNT=0.
- Every cycle of a random EN/LAST/LOAD run -> T one-hot and equals 1<<CNT.

Source files
------------

// File: rtl/timestep_sequencer.sv
// Timestep counter for the control unit: one-hot step bus, end-of-instruction/load/stall
// handling, and saturating cycle/instruction performance counters. State updates on falling edge.
module timestep_sequencer #(
  parameter int unsigned STEP_W = 2,
  parameter int unsigned PERF_W = 16
) (
  input  logic                    CLKb,
  input  logic                    CLR,
  input  logic                    EN,
  input  logic                    LAST,
  input  logic                    LOAD,
  input  logic [STEP_W-1:0]       LD_VAL,
  output logic [STEP_W-1:0]       CNT,
  output logic [(2**STEP_W)-1:0]  T,
  output logic                    WRAP,
  output logic                    OVF,
  output logic [PERF_W-1:0]       CYCLES,
  output logic [PERF_W-1:0]       INSTRS
);

  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              ovf_q, ovf_d;
  logic [PERF_W-1:0] cycles_q, cycles_d;
  logic [PERF_W-1:0] instrs_q, instrs_d;

  always_comb begin
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    ovf_d    = ovf_q;
    cycles_d = cycles_q;
    instrs_d = instrs_q;
    if (EN) begin
      if (cycles_q != '1) cycles_d = cycles_q + PERF_W'(1);
      if (LOAD) begin
        cnt_d = LD_VAL;
      end else if (LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
        if (instrs_q != '1) instrs_d = instrs_q + PERF_W'(1);
      end else if (cnt_q == '1) begin
        // Ran off the end of the step range without an end-of-instruction marker.
        cnt_d  = '0;
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + STEP_W'(1);
      end
    end
  end

  always_ff @(negedge CLKb or posedge CLR) begin
    if (CLR) begin
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cycles_q <= '0;
      instrs_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
      instrs_q <= instrs_d;
    end
  end

  always_comb begin
    T        = '0;
    T[cnt_q] = 1'b1;
  end

  assign CNT    = cnt_q;
  assign WRAP   = wrap_q;
  assign OVF    = ovf_q;
  assign CYCLES = cycles_q;
  assign INSTRS = instrs_q;

endmodule

// File: tb/tb_timestep_sequencer.sv
// Bench for timestep_sequencer: directed scenarios plus a random run, checked against
// an arithmetic reference model; a second instance with PERF_W=4 exercises saturation.
module tb_timestep_sequencer;

  localparam int NSTEP = 4;
  localparam int MAX16 = 65535;
  localparam int MAX4  = 15;

  logic       CLKb, CLR, EN, LAST, LOAD;
  logic [1:0] LD_VAL;

  logic [1:0]  cnt_a, cnt_b;
  logic [3:0]  t_a, t_b;
  logic        wrap_a, wrap_b, ovf_a, ovf_b;
  logic [15:0] cycles_a, instrs_a;
  logic [3:0]  cycles_b, instrs_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt, m_wrap, m_ovf, m_cyc, m_ins;

  timestep_sequencer #(.STEP_W(2), .PERF_W(16)) dut (
    .CLKb(CLKb), .CLR(CLR), .EN(EN), .LAST(LAST), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .CNT(cnt_a), .T(t_a), .WRAP(wrap_a), .OVF(ovf_a), .CYCLES(cycles_a), .INSTRS(instrs_a)
  );

  timestep_sequencer #(.STEP_W(2), .PERF_W(4)) dut4 (
    .CLKb(CLKb), .CLR(CLR), .EN(EN), .LAST(LAST), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .CNT(cnt_b), .T(t_b), .WRAP(wrap_b), .OVF(ovf_b), .CYCLES(cycles_b), .INSTRS(instrs_b)
  );

  initial begin
    CLKb = 1'b1;
    forever #5 CLKb = ~CLKb;
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".cnt"},    int'(cnt_a), m_cnt);
    check_val({tag, ".t"},      int'(t_a), 1 << m_cnt);
    check_val({tag, ".onehot"}, int'($onehot(t_a)), 1);
    check_val({tag, ".wrap"},   int'(wrap_a), m_wrap);
    check_val({tag, ".ovf"},    int'(ovf_a), m_ovf);
    check_val({tag, ".cycles"}, int'(cycles_a), sat(m_cyc, MAX16));
    check_val({tag, ".instrs"}, int'(instrs_a), sat(m_ins, MAX16));
    check_val({tag, ".cnt4"},    int'(cnt_b), m_cnt);
    check_val({tag, ".cycles4"}, int'(cycles_b), sat(m_cyc, MAX4));
    check_val({tag, ".instrs4"}, int'(instrs_b), sat(m_ins, MAX4));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wrap = 0; m_ovf = 0; m_cyc = 0; m_ins = 0;
  endtask

  // One falling edge with the given inputs; model advances, then outputs sampled on rising edge.
  task automatic step(input string tag, input logic en, input logic last, input logic load,
                      input logic [1:0] ld);
    EN = en; LAST = last; LOAD = load; LD_VAL = ld;
    @(negedge CLKb);
    if (!en) begin
      m_wrap = 0;
    end else begin
      m_cyc++;
      if (load) begin
        m_cnt = int'(ld); m_wrap = 0;
      end else if (last) begin
        m_cnt = 0; m_wrap = 1; m_ins++;
      end else if (m_cnt == NSTEP - 1) begin
        m_cnt = 0; m_wrap = 1; m_ovf = 1;
      end else begin
        m_cnt++; m_wrap = 0;
      end
    end
    @(posedge CLKb);
    check_all(tag);
  endtask

  // Called just after a rising edge so the pulse lands between active edges.
  task automatic pulse_reset(input string tag);
    CLR = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".during"});
    CLR = 1'b0;
    #1;
    check_all({tag, ".after"});
  endtask

  initial begin
    CLR = 1'b1; EN = 1'b0; LAST = 1'b0; LOAD = 1'b0; LD_VAL = 2'd0;
    model_reset();
    @(posedge CLKb);
    check_all("reset");
    CLR = 1'b0;

    // End-of-instruction, then LOAD overriding LAST
    step("adv1", 1, 0, 0, 2'd0);
    step("last", 1, 1, 0, 2'd0);
    step("wrapclr", 1, 0, 0, 2'd0);
    step("loadlast", 1, 1, 1, 2'd2);

    // Stall holds everything even with LAST and LOAD asserted
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 1, 2'd1);

    // Load of the current value: no change, no wrap, cycle still counted
    step("loadsame", 1, 0, 1, 2'd2);

    // Asynchronous clear mid-instruction (CNT=2), no edge involved
    pulse_reset("clrmid");

    // Natural wrap sets OVF
    for (int i = 0; i < 5; i++) step("natwrap", 1, 0, 0, 2'd0);

    // LAST at final step: wrap without overflow
    pulse_reset("clr2");
    for (int i = 0; i < 3; i++) step("tolast", 1, 0, 0, 2'd0);
    step("lastatend", 1, 1, 0, 2'd0);

    // Saturation of the narrow counters
    pulse_reset("clr3");
    for (int i = 0; i < 20; i++) step("sat", 1, 1, 0, 2'd0);

    // Random run
    pulse_reset("clr4");
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
